drive_sequencer: RTL and testbench

//  Mission-level controller between the line follower, beacon classifier, current limiter and H-bridge.

---
 rtl/drive_sequencer.sv | 152 +++++++++++++++
 tb/tb_drive_sequencer.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/drive_sequencer.sv
// Mission controller: arbitrates line-follow, beacon dwell/evade and over-current cool-down,
// and gates the H-bridge drive code with a fixed-duty PWM frame.
module drive_sequencer #(
  parameter int unsigned PWM_PERIOD = 1666667,
  parameter int unsigned PWM_DUTY   = 1000000,
  parameter int unsigned DWELL_CYC  = 200000000,
  parameter int unsigned REV_CYC    = 50000000,
  parameter int unsigned PIVOT_CYC  = 70000000,
  parameter int unsigned ILIM_CYC   = 10000000,
  parameter int unsigned COOL_CYC   = 100000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [3:0] line_cmd,
  input  logic       beacon_valid,
  input  logic [3:0] beacon_class,
  input  logic [1:0] ilim_n,
  output logic [3:0] ja,
  output logic [2:0] state,
  output logic       fault,
  output logic [7:0] fault_count
);

  // state | meaning: IDLE motors off | FOLLOW pass line_cmd | DWELL friendly stop |
  //         REVERSE back off | PIVOT turn right | FAULT over-current cool-down
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FOLLOW  = 3'd1,
    ST_DWELL   = 3'd2,
    ST_REVERSE = 3'd3,
    ST_PIVOT   = 3'd4,
    ST_FAULT   = 3'd5
  } state_t;

  localparam logic [3:0] CMD_REV    = 4'b0101;
  localparam logic [3:0] CMD_PIVR   = 4'b0110;
  localparam logic [3:0] CLS_FRIEND = 4'b0011;
  localparam logic [3:0] CLS_CRIM   = 4'b1100;
  localparam logic [3:0] CLS_NONE   = 4'b0000;

  state_t      state_q, state_d;
  logic [31:0] tmr_q, tmr_d;
  logic [31:0] oc_q, oc_d;
  logic [31:0] pwm_q, pwm_d;
  logic        armed_q, armed_d;
  logic [3:0]  ja_q, ja_d;
  logic [7:0]  fcnt_q, fcnt_d;

  logic        over_cur;
  logic        pwm_on;
  logic        trip;
  logic        tmr_done;
  logic [3:0]  cmd;

  assign over_cur = (ilim_n != 2'b11);
  assign pwm_on   = (pwm_q < PWM_DUTY);
  assign tmr_done = (tmr_q == 32'd0);
  assign trip     = (oc_q == ILIM_CYC) &&
                    (state_q inside {ST_FOLLOW, ST_DWELL, ST_REVERSE, ST_PIVOT});

  always_comb begin
    state_d = state_q;
    armed_d = armed_q;
    fcnt_d  = fcnt_q;

    if (beacon_valid && (beacon_class == CLS_NONE)) armed_d = 1'b1;

    if (!enable) begin
      state_d = ST_IDLE;
    end else if (trip) begin
      state_d = ST_FAULT;
      if (fcnt_q != 8'hFF) fcnt_d = fcnt_q + 8'd1;
    end else begin
      case (state_q)
        ST_IDLE:    state_d = ST_FOLLOW;
        ST_FOLLOW: begin
          if (beacon_valid && armed_q) begin
            if (beacon_class == CLS_FRIEND) begin
              state_d = ST_DWELL;
              armed_d = 1'b0;
            end else if (beacon_class == CLS_CRIM) begin
              state_d = ST_REVERSE;
              armed_d = 1'b0;
            end
          end
        end
        ST_DWELL:   if (tmr_done) state_d = ST_FOLLOW;
        ST_REVERSE: if (tmr_done) state_d = ST_PIVOT;
        ST_PIVOT:   if (tmr_done) state_d = ST_FOLLOW;
        ST_FAULT:   if (tmr_done) state_d = ST_FOLLOW;
        default:    state_d = ST_IDLE;
      endcase
    end

    // Down-counter loaded with N-1 on entry so the state lasts exactly N clocks.
    tmr_d = tmr_q;
    if (state_d != state_q) begin
      case (state_d)
        ST_DWELL:   tmr_d = DWELL_CYC - 1;
        ST_REVERSE: tmr_d = REV_CYC - 1;
        ST_PIVOT:   tmr_d = PIVOT_CYC - 1;
        ST_FAULT:   tmr_d = COOL_CYC - 1;
        default:    tmr_d = 32'd0;
      endcase
    end else if (!tmr_done) begin
      tmr_d = tmr_q - 32'd1;
    end

    // Held at zero through FAULT so counting restarts from 0 back in FOLLOW.
    oc_d = 32'd0;
    if (enable && !trip && (state_q != ST_FAULT) && over_cur) begin
      oc_d = (oc_q == ILIM_CYC) ? oc_q : oc_q + 32'd1;
    end

    pwm_d = (pwm_q == PWM_PERIOD - 1) ? 32'd0 : pwm_q + 32'd1;

    case (state_q)
      ST_FOLLOW:  cmd = line_cmd;
      ST_REVERSE: cmd = CMD_REV;
      ST_PIVOT:   cmd = CMD_PIVR;
      default:    cmd = 4'b0000;
    endcase
    ja_d = pwm_on ? cmd : 4'b0000;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      tmr_q   <= 32'd0;
      oc_q    <= 32'd0;
      pwm_q   <= 32'd0;
      armed_q <= 1'b1;
      ja_q    <= 4'b0000;
      fcnt_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      oc_q    <= oc_d;
      pwm_q   <= pwm_d;
      armed_q <= armed_d;
      ja_q    <= ja_d;
      fcnt_q  <= fcnt_d;
    end
  end

  assign ja          = ja_q;
  assign state       = state_q;
  assign fault       = (state_q == ST_FAULT);
  assign fault_count = fcnt_q;

endmodule

// File: tb/tb_drive_sequencer.sv
// Directed scenarios for drive_sequencer; expected outputs queued per target cycle and
// checked by an independent negedge monitor.
module tb_drive_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic [3:0] line_cmd;
  logic       beacon_valid;
  logic [3:0] beacon_class;
  logic [1:0] ilim_n;
  logic [3:0] ja;
  logic [2:0] state;
  logic       fault;
  logic [7:0] fault_count;

  drive_sequencer #(
    .PWM_PERIOD(10), .PWM_DUTY(6), .DWELL_CYC(20), .REV_CYC(8),
    .PIVOT_CYC(12), .ILIM_CYC(5), .COOL_CYC(15)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .line_cmd(line_cmd),
    .beacon_valid(beacon_valid), .beacon_class(beacon_class), .ilim_n(ilim_n),
    .ja(ja), .state(state), .fault(fault), .fault_count(fault_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         tgt;
    string      nm;
    logic [2:0] st;
    bit         cj;
    logic [3:0] ja;
    logic [7:0] fc;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int   n_vec = 0;
  int   n_bad = 0;
  int   base  = 0;
  int   po    = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go(input int t);
    while (cyc - base < t) tick();
  endtask

  task automatic chk(input int t, input string nm, input logic [2:0] s, input bit cj,
                     input logic [3:0] j, input logic [7:0] fc);
    exp_t e;
    e.tgt = base + t;
    e.nm  = nm;
    e.st  = s;
    e.cj  = cj;
    e.ja  = j;
    e.fc  = fc;
    sb.push_back(e);
  endtask

  // Drive code is present only in frame slots 1..6 after the PWM origin (one-clock output lag).
  function automatic logic [3:0] gated(input int t, input logic [3:0] c);
    int ph;
    ph = (t - po) % 10;
    return (ph >= 1 && ph <= 6) ? c : 4'b0000;
  endfunction

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].tgt <= cyc) begin
      cur = sb.pop_front();
      n_vec++;
      if (cur.tgt != cyc) begin
        n_bad++;
        $display("FAIL %s: checked at cycle %0d, required cycle %0d", cur.nm, cyc, cur.tgt);
      end else if (state !== cur.st || fault !== (cur.st == 3'd5) ||
                   fault_count !== cur.fc || (cur.cj && ja !== cur.ja)) begin
        n_bad++;
        $display("FAIL %s (t=%0d): got state=%0d ja=%b fault=%b fault_count=%0d, required state=%0d ja=%b fault=%b fault_count=%0d",
                 cur.nm, cyc - base, state, ja, fault, fault_count,
                 cur.st, cur.ja, (cur.st == 3'd5), cur.fc);
      end
    end
  end

  initial begin
    rst = 1'b1; enable = 1'b0; line_cmd = 4'b0000;
    beacon_valid = 1'b0; beacon_class = 4'b0000; ilim_n = 2'b11;
    repeat (3) tick();
    base = cyc;
    po   = 0;

    // Reset state, then plain FOLLOW with the 6-on/4-off PWM frame
    chk(0, "reset", 3'd0, 1'b1, 4'b0000, 8'd0);
    rst = 1'b0; enable = 1'b1; line_cmd = 4'b1010;
    for (int t = 1; t <= 20; t++)
      chk(t, "pwm_follow", (t == 0) ? 3'd0 : 3'd1, 1'b1,
          (t >= 2) ? gated(t, 4'b1010) : 4'b0000, 8'd0);
    go(20);

    // Friendly beacon dwell, ignored repeat, re-arm by a none report
    beacon_valid = 1'b1; beacon_class = 4'b0011;
    chk(21, "dwell_enter",   3'd2, 1'b1, 4'b1010, 8'd0);
    chk(22, "dwell_ja0",     3'd2, 1'b1, 4'b0000, 8'd0);
    chk(40, "dwell_last",    3'd2, 1'b1, 4'b0000, 8'd0);
    chk(41, "dwell_exit",    3'd1, 1'b1, 4'b0000, 8'd0);
    chk(42, "follow_resume", 3'd1, 1'b1, 4'b1010, 8'd0);
    go(21); beacon_valid = 1'b0;
    go(45); beacon_valid = 1'b1; beacon_class = 4'b0011;
    chk(46, "no_rearm_a", 3'd1, 1'b0, 4'b0000, 8'd0);
    chk(47, "no_rearm_b", 3'd1, 1'b0, 4'b0000, 8'd0);
    go(46); beacon_valid = 1'b0;
    go(47); beacon_valid = 1'b1; beacon_class = 4'b0000;
    go(48); beacon_valid = 1'b0;
    go(49); beacon_valid = 1'b1; beacon_class = 4'b0011;
    chk(50, "rearm_dwell",  3'd2, 1'b0, 4'b0000, 8'd0);
    chk(69, "dwell2_last",  3'd2, 1'b0, 4'b0000, 8'd0);
    chk(70, "dwell2_exit",  3'd1, 1'b0, 4'b0000, 8'd0);
    go(50); beacon_valid = 1'b0;

    // Criminal beacon: reverse then pivot, both PWM-gated
    go(71); beacon_valid = 1'b1; beacon_class = 4'b0000;
    go(72); beacon_class = 4'b1100;
    chk(73, "rev_enter",   3'd3, 1'b1, 4'b1010, 8'd0);
    chk(74, "rev_on",      3'd3, 1'b1, 4'b0101, 8'd0);
    chk(77, "rev_off",     3'd3, 1'b1, 4'b0000, 8'd0);
    chk(80, "rev_last",    3'd3, 1'b1, 4'b0000, 8'd0);
    chk(81, "pivot_enter", 3'd4, 1'b1, 4'b0101, 8'd0);
    chk(82, "pivot_on",    3'd4, 1'b1, 4'b0110, 8'd0);
    chk(87, "pivot_off",   3'd4, 1'b1, 4'b0000, 8'd0);
    chk(92, "pivot_last",  3'd4, 1'b1, 4'b0110, 8'd0);
    chk(93, "pivot_exit",  3'd1, 1'b1, 4'b0110, 8'd0);
    chk(94, "follow_back", 3'd1, 1'b1, 4'b1010, 8'd0);
    go(73); beacon_valid = 1'b0;

    // Over-current: 4-clock burst no trip, 5-clock burst trips, cool-down
    go(95); ilim_n = 2'b10;
    chk(99,  "oc_burst4",  3'd1, 1'b0, 4'b0000, 8'd0);
    chk(100, "oc_cleared", 3'd1, 1'b0, 4'b0000, 8'd0);
    chk(106, "trip",       3'd5, 1'b0, 4'b0000, 8'd1);
    chk(112, "fault_ja0",  3'd5, 1'b1, 4'b0000, 8'd1);
    chk(120, "cool_last",  3'd5, 1'b0, 4'b0000, 8'd1);
    chk(121, "cool_done",  3'd1, 1'b0, 4'b0000, 8'd1);
    go(99);  ilim_n = 2'b11;
    go(100); ilim_n = 2'b10;
    go(105); ilim_n = 2'b11;
    go(121);

    // Trip and criminal strobe together: trip wins, beacon stays armed
    beacon_valid = 1'b1; beacon_class = 4'b0000;
    go(122); beacon_valid = 1'b0; ilim_n = 2'b01;
    chk(127, "pre_trip2",      3'd1, 1'b0, 4'b0000, 8'd1);
    chk(128, "trip_vs_beacon", 3'd5, 1'b0, 4'b0000, 8'd2);
    chk(142, "cool2_last",     3'd5, 1'b0, 4'b0000, 8'd2);
    chk(143, "cool2_done",     3'd1, 1'b0, 4'b0000, 8'd2);
    chk(144, "armed_kept",     3'd3, 1'b0, 4'b0000, 8'd2);
    chk(146, "rev_running",    3'd3, 1'b0, 4'b0000, 8'd2);
    go(127); ilim_n = 2'b11; beacon_valid = 1'b1; beacon_class = 4'b1100;
    go(128); beacon_valid = 1'b0;
    go(143); beacon_valid = 1'b1; beacon_class = 4'b1100;
    go(144); beacon_valid = 1'b0;

    // rst mid-REVERSE, then enable drop mid-DWELL with no resume
    go(147); rst = 1'b1;
    chk(148, "rst_mid_rev", 3'd0, 1'b1, 4'b0000, 8'd0);
    go(148); rst = 1'b0; po = 148;
    chk(149, "post_rst_follow", 3'd1, 1'b1, 4'b0000, 8'd0);
    chk(151, "dwell_after_rst", 3'd2, 1'b0, 4'b0000, 8'd0);
    chk(155, "dwell_mid",       3'd2, 1'b0, 4'b0000, 8'd0);
    chk(156, "en_drop",         3'd0, 1'b1, 4'b0000, 8'd0);
    chk(157, "idle_hold",       3'd0, 1'b1, 4'b0000, 8'd0);
    chk(159, "no_resume",       3'd1, 1'b0, 4'b0000, 8'd0);
    chk(160, "follow_ja",       3'd1, 1'b1, gated(160, 4'b1010), 8'd0);
    chk(161, "cmd_pass",        3'd1, 1'b1, gated(161, 4'b1001), 8'd0);
    chk(165, "gate_off",        3'd1, 1'b1, gated(165, 4'b1001), 8'd0);
    go(150); beacon_valid = 1'b1; beacon_class = 4'b0011;
    go(151); beacon_valid = 1'b0;
    go(155); enable = 1'b0;
    go(158); enable = 1'b1;
    go(160); line_cmd = 4'b1001;
    go(166);

    for (int g = 0; g < 50 && sb.size() > 0; g++) tick();
    if (sb.size() > 0) begin
      n_bad++;
      $display("FAIL sb_drain: %0d expectations never reached, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
